// File: rtl/oss_hal_regbank.sv
// ----------------------------------------------------------------------------
// oss_hal_regbank
//   Word-addressed HAL register block with an integrated multi-cycle
//   arithmetic engine (add, subtract, unsigned shift-add multiply).
//
//   Word map (index = byte address >> 2):
//     0 ID (RO) | 1 CTRL | 2 STATUS | 3 OP_A | 4 OP_B | 5 RES_LO (RO)
//     6 RES_HI (RO) | 7..6+NUM_SCRATCH SCRATCH[i] (R/W) | others read 0
//
//   Ports:
//     hal_clk                   clock, rising edge
//     hal_reset                 asynchronous active-high reset
//     reg_itf_write_in          write strobe (one transfer per high cycle)
//     reg_itf_read_in           read strobe (one transfer per high cycle)
//     reg_itf_addr_in           byte address, low two bits ignored
//     reg_itf_writedata_in      write data
//     reg_itf_readdata_out      registered read data, holds when not valid
//     reg_itf_readdatavalid_out one-cycle pulse qualifying readdata
//     irq_out                   STATUS.done & CTRL.irq_en
// ----------------------------------------------------------------------------
module oss_hal_regbank #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter logic [31:0] HAL_ID      = 32'h055A_0002
) (
  input  logic              hal_clk,
  input  logic              hal_reset,
  input  logic              reg_itf_write_in,
  input  logic              reg_itf_read_in,
  input  logic [ADDR_W-1:0] reg_itf_addr_in,
  input  logic [DATA_W-1:0] reg_itf_writedata_in,
  output logic [DATA_W-1:0] reg_itf_readdata_out,
  output logic              reg_itf_readdatavalid_out,
  output logic              irq_out
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  localparam logic [IDX_W-1:0] W_ID     = IDX_W'(0);
  localparam logic [IDX_W-1:0] W_CTRL   = IDX_W'(1);
  localparam logic [IDX_W-1:0] W_STATUS = IDX_W'(2);
  localparam logic [IDX_W-1:0] W_OPA    = IDX_W'(3);
  localparam logic [IDX_W-1:0] W_OPB    = IDX_W'(4);
  localparam logic [IDX_W-1:0] W_RESLO  = IDX_W'(5);
  localparam logic [IDX_W-1:0] W_RESHI  = IDX_W'(6);
  localparam int unsigned      W_SCR0   = 7;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // ID constant truncated or zero-extended to the register width.
  localparam logic [DATA_W+31:0] HAL_ID_EXT = {{DATA_W{1'b0}}, HAL_ID};
  localparam logic [DATA_W-1:0]  ID_VAL     = HAL_ID_EXT[DATA_W-1:0];

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state_q;
  logic [1:0]          op_q;
  logic                irq_en_q;
  logic                done_q;
  logic                err_q;
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic [DATA_W-1:0]   res_lo_q;
  logic [DATA_W-1:0]   res_hi_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;

  // Engine-private copies so OP_A/OP_B can be rewritten while busy.
  logic [1:0]          eng_op_q;
  logic [2*DATA_W-1:0] eng_a_q;    // multiplicand, shifts left each step
  logic [DATA_W-1:0]   eng_b_q;    // multiplier, shifts right each step
  logic [2*DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [IDX_W-1:0]    word_idx;
  logic                busy;
  logic                wr_ctrl, wr_status, wr_opa, wr_opb;
  logic                start_req, start_ok, start_bad;
  logic                finish;
  logic [DATA_W:0]     add_full;
  logic [DATA_W:0]     sub_full;
  logic [2*DATA_W-1:0] mul_acc_d;
  logic [DATA_W-1:0]   rd_data_d;
  logic [DATA_W-1:0]   scratch_val [NUM_SCRATCH];
  logic                unused_addr_bits;

  assign word_idx         = reg_itf_addr_in[ADDR_W-1:2];
  assign unused_addr_bits = ^reg_itf_addr_in[1:0];
  assign busy             = (state_q == S_RUN);

  assign wr_ctrl   = reg_itf_write_in && (word_idx == W_CTRL);
  assign wr_status = reg_itf_write_in && (word_idx == W_STATUS);
  assign wr_opa    = reg_itf_write_in && (word_idx == W_OPA);
  assign wr_opb    = reg_itf_write_in && (word_idx == W_OPB);

  // Start uses the op field carried by the same CTRL write.
  assign start_req = wr_ctrl && reg_itf_writedata_in[0];
  assign start_ok  = start_req && !busy && (reg_itf_writedata_in[2:1] != OP_RSV);
  assign start_bad = start_req && !start_ok;

  assign add_full  = {1'b0, eng_a_q[DATA_W-1:0]} + {1'b0, eng_b_q};
  // Top bit of the widened difference is the borrow (A < B unsigned).
  assign sub_full  = {1'b0, eng_a_q[DATA_W-1:0]} - {1'b0, eng_b_q};
  assign mul_acc_d = acc_q + (eng_b_q[0] ? eng_a_q : '0);

  assign finish = busy && ((eng_op_q != OP_MUL) || (cnt_q == CNT_W'(DATA_W - 1)));

  // Scratch registers.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
      logic [DATA_W-1:0] scr_q;
      logic              scr_wr;
      assign scr_wr = reg_itf_write_in && (word_idx == IDX_W'(W_SCR0 + gi));
      always_ff @(posedge hal_clk or posedge hal_reset) begin
        if (hal_reset) begin
          scr_q <= '0;
        end else if (scr_wr) begin
          scr_q <= reg_itf_writedata_in;
        end
      end
      assign scratch_val[gi] = scr_q;
    end
  endgenerate

  // Read mux over current (pre-write) register values.
  always_comb begin
    rd_data_d = '0;
    case (word_idx)
      W_ID:     rd_data_d = ID_VAL;
      W_CTRL:   rd_data_d = DATA_W'({irq_en_q, op_q, 1'b0});
      W_STATUS: rd_data_d = DATA_W'({err_q, done_q, busy});
      W_OPA:    rd_data_d = op_a_q;
      W_OPB:    rd_data_d = op_b_q;
      W_RESLO:  rd_data_d = res_lo_q;
      W_RESHI:  rd_data_d = res_hi_q;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (word_idx == IDX_W'(W_SCR0 + i)) rd_data_d = scratch_val[i];
        end
      end
    endcase
  end

  always_ff @(posedge hal_clk or posedge hal_reset) begin
    if (hal_reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      eng_op_q   <= '0;
      eng_a_q    <= '0;
      eng_b_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      rd_valid_q <= reg_itf_read_in;
      if (reg_itf_read_in) rd_data_q <= rd_data_d;

      if (wr_ctrl) begin
        op_q     <= reg_itf_writedata_in[2:1];
        irq_en_q <= reg_itf_writedata_in[3];
      end
      if (wr_opa) op_a_q <= reg_itf_writedata_in;
      if (wr_opb) op_b_q <= reg_itf_writedata_in;

      if (wr_status) begin
        if (reg_itf_writedata_in[1]) done_q <= 1'b0;
        if (reg_itf_writedata_in[2]) err_q  <= 1'b0;
      end
      if (start_bad) err_q <= 1'b1;

      if (state_q == S_IDLE) begin
        if (start_ok) begin
          state_q  <= S_RUN;
          done_q   <= 1'b0;
          eng_op_q <= reg_itf_writedata_in[2:1];
          eng_a_q  <= {{DATA_W{1'b0}}, op_a_q};
          eng_b_q  <= op_b_q;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
      end else begin
        if (eng_op_q == OP_MUL) begin
          acc_q   <= mul_acc_d;
          eng_a_q <= eng_a_q << 1;
          eng_b_q <= eng_b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
        end
        if (finish) begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;  // placed after the W1C clear so set wins
          case (eng_op_q)
            OP_ADD: begin
              res_lo_q <= add_full[DATA_W-1:0];
              res_hi_q <= {{(DATA_W-1){1'b0}}, add_full[DATA_W]};
            end
            OP_SUB: begin
              res_lo_q <= sub_full[DATA_W-1:0];
              res_hi_q <= {{(DATA_W-1){1'b0}}, sub_full[DATA_W]};
            end
            default: begin
              res_lo_q <= mul_acc_d[DATA_W-1:0];
              res_hi_q <= mul_acc_d[2*DATA_W-1:DATA_W];
            end
          endcase
        end
      end
    end
  end

  assign reg_itf_readdata_out      = rd_data_q;
  assign reg_itf_readdatavalid_out = rd_valid_q;
  assign irq_out                   = done_q & irq_en_q;

endmodule

// File: tb/tb_oss_hal_regbank.sv
module tb_oss_hal_regbank;

  logic        hal_clk = 1'b0;
  logic        hal_reset = 1'b1;
  logic        reg_itf_write_in = 1'b0;
  logic        reg_itf_read_in = 1'b0;
  logic [5:0]  reg_itf_addr_in = '0;
  logic [31:0] reg_itf_writedata_in = '0;
  logic [31:0] reg_itf_readdata_out;
  logic        reg_itf_readdatavalid_out;
  logic        irq_out;

  oss_hal_regbank dut (
    .hal_clk                   (hal_clk),
    .hal_reset                 (hal_reset),
    .reg_itf_write_in          (reg_itf_write_in),
    .reg_itf_read_in           (reg_itf_read_in),
    .reg_itf_addr_in           (reg_itf_addr_in),
    .reg_itf_writedata_in      (reg_itf_writedata_in),
    .reg_itf_readdata_out      (reg_itf_readdata_out),
    .reg_itf_readdatavalid_out (reg_itf_readdatavalid_out),
    .irq_out                   (irq_out)
  );

  always #5 hal_clk = ~hal_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge hal_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    int          idx;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: architectural register state plus a countdown for
  // the running operation whose result is computed up front.
  logic [31:0] m_a, m_b, m_lo, m_hi;
  logic [31:0] m_scr [4];
  logic [1:0]  m_op;
  logic        m_irq, m_busy, m_done, m_err;
  int          m_remain;
  logic [63:0] m_pend;

  task automatic model_reset();
    m_a = 0; m_b = 0; m_lo = 0; m_hi = 0;
    for (int i = 0; i < 4; i++) m_scr[i] = 0;
    m_op = 0; m_irq = 0; m_busy = 0; m_done = 0; m_err = 0;
    m_remain = 0; m_pend = 0;
  endtask

  function automatic logic [63:0] calc(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        return {31'b0, s[32], s[31:0]};
      end
      2'b01:   return {31'b0, (a < b), a - b};
      default: return {32'b0, a} * {32'b0, b};
    endcase
  endfunction

  function automatic logic [31:0] model_read(int idx);
    case (idx)
      0: return 32'h055A_0002;
      1: return {28'b0, m_irq, m_op, 1'b0};
      2: return {29'b0, m_err, m_done, m_busy};
      3: return m_a;
      4: return m_b;
      5: return m_lo;
      6: return m_hi;
      7, 8, 9, 10: return m_scr[idx-7];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(bit wr, int idx, logic [31:0] d);
    bit busy_pre;
    bit fin;
    busy_pre = m_busy;
    fin = 0;
    if (m_busy) begin
      m_remain--;
      if (m_remain == 0) begin
        m_busy = 0; fin = 1; m_done = 1;
        m_lo = m_pend[31:0]; m_hi = m_pend[63:32];
      end
    end
    if (wr) begin
      case (idx)
        1: begin
          m_op = d[2:1]; m_irq = d[3];
          if (d[0]) begin
            if (busy_pre || d[2:1] == 2'b11) m_err = 1;
            else begin
              m_busy = 1; m_done = 0;
              m_remain = (d[2:1] == 2'b10) ? 32 : 1;
              m_pend = calc(d[2:1], m_a, m_b);
            end
          end
        end
        2: begin
          if (d[1] && !fin) m_done = 0;
          if (d[2]) m_err = 0;
        end
        3: m_a = d;
        4: m_b = d;
        7, 8, 9, 10: m_scr[idx-7] = d;
        default: ;
      endcase
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic do_cycle(bit wr, bit rd, int idx, logic [31:0] d);
    exp_t e;
    reg_itf_write_in     = wr;
    reg_itf_read_in      = rd;
    reg_itf_addr_in      = {4'(idx), 2'($urandom_range(0, 3))};
    reg_itf_writedata_in = d;
    if (rd) begin
      e.data = model_read(idx);
      e.cyc  = cyc + 1;
      e.idx  = idx;
      exp_q.push_back(e);
    end
    @(posedge hal_clk);
    model_edge(wr, idx, d);
    @(negedge hal_clk);
    checks++;
    if (irq_out !== (m_done & m_irq)) begin
      errors++;
      $display("FAIL irq_level: cyc=%0d irq_out=%b expected=%b", cyc, irq_out, m_done & m_irq);
    end
  endtask

  task automatic wr(int idx, logic [31:0] d); do_cycle(1, 0, idx, d); endtask
  task automatic rd(int idx);                 do_cycle(0, 1, idx, 32'h0); endtask
  task automatic rw(int idx, logic [31:0] d); do_cycle(1, 1, idx, d); endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 32'h0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    reg_itf_write_in = 0;
    reg_itf_read_in  = 0;
    #2;
    hal_reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (irq_out !== 1'b0 || reg_itf_readdatavalid_out !== 1'b0 || reg_itf_readdata_out !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: irq=%b valid=%b rdata=%h expected 0/0/0",
               irq_out, reg_itf_readdatavalid_out, reg_itf_readdata_out);
    end
    @(posedge hal_clk);
    @(negedge hal_clk);
    #2;
    hal_reset = 1'b0;
  endtask

  // Monitor: pops one expectation per valid pulse, checks data and timing.
  always @(negedge hal_clk) begin
    if (!hal_reset && reg_itf_readdatavalid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid: cyc=%0d rdata=%h expected no valid", cyc, reg_itf_readdata_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (reg_itf_readdata_out !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL read_w%0d: got data=%h at cyc %0d, expected data=%h at cyc %0d",
                   e.idx, reg_itf_readdata_out, cyc, e.data, e.cyc);
        end else begin
          $display("read word %0d -> %h (cyc %0d)", e.idx, reg_itf_readdata_out, cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(negedge hal_clk);
    @(negedge hal_clk);
    checks++;
    if (irq_out !== 1'b0 || reg_itf_readdatavalid_out !== 1'b0 || reg_itf_readdata_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: irq=%b valid=%b rdata=%h expected 0/0/0",
               irq_out, reg_itf_readdatavalid_out, reg_itf_readdata_out);
    end
    #2 hal_reset = 1'b0;

    // ID and STATUS after reset, then a full map sweep.
    rd(0); rd(2);
    for (int i = 0; i < 16; i++) rd(i);

    // Add with carry, then W1C of done.
    wr(3, 32'hFFFF_FFFF); wr(4, 32'h2); wr(1, 32'h1);
    rd(2); rd(2); rd(5); rd(6);
    wr(2, 32'h2); rd(2);

    // Subtract with borrow.
    wr(3, 32'h3); wr(4, 32'h5); wr(1, 32'h3);
    idle(2); rd(5); rd(6);

    // Full-width multiply: poll STATUS every cycle to pin completion time.
    wr(3, 32'hFFFF_FFFF); wr(4, 32'hFFFF_FFFF); wr(1, 32'h5);
    for (int i = 0; i < 33; i++) rd(2);
    rd(5); rd(6);

    // Interrupt-enabled multiply, restart while busy, reserved op.
    wr(2, 32'h6);
    wr(3, 32'h7); wr(4, 32'h6); wr(1, 32'hD);
    idle(33); rd(5); rd(2);
    wr(1, 32'hD); wr(1, 32'hD); wr(3, 32'h64); wr(4, 32'h9);
    idle(33); rd(2); rd(5); rd(6);
    wr(1, 32'h7); rd(2); rd(1);

    // W1C done in the completion cycle: set wins.
    wr(1, 32'h1); rw(2, 32'h2); rd(2);

    // Scratch, same-cycle read/write, RO and unmapped writes.
    for (int i = 0; i < 4; i++) wr(7 + i, 32'hA0 + i);
    rw(8, 32'h1234_5678); rd(8);
    for (int i = 0; i < 4; i++) rd(7 + i);
    wr(5, 32'hDEAD_BEEF); wr(11, 32'hCAFE_F00D);
    rd(5); rd(11); rd(15);

    // Asynchronous reset in the middle of a multiply.
    wr(3, 32'h1234); wr(4, 32'h5678); wr(1, 32'hD);
    idle(10);
    do_reset();
    rd(2); rd(5); rd(6); rd(1); rd(3); rd(7);
    wr(3, 32'd10); wr(4, 32'd20); wr(1, 32'h1);
    idle(2); rd(5); rd(6); rd(2);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      int r, idx;
      logic [31:0] d;
      r   = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      d   = $urandom;
      if (idx == 3 || idx == 4) d = (r[0]) ? d : 32'($urandom_range(0, 255));
      if (r <= 3)      do_cycle(0, 1, idx, d);
      else if (r <= 6) do_cycle(1, 0, idx, d);
      else if (r == 7) do_cycle(1, 1, idx, d);
      else             idle(1);
    end

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding_reads: %0d reads without valid, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oss_hal_regbank.md
# oss_hal_regbank

Parametrised second-generation OPS-SAT Swansea HAL register block. Word-addressed register file (ID, control, status, two operands, 2-word result, N scratch) with a handshaked read path and an integrated multi-cycle arithmetic engine (add, subtract, unsigned shift-add multiply) driven by a start/busy/done protocol with a sticky-status interrupt. Sits directly behind the host register interface in the user-logic region.

## Interface
- DATA_W, 32, register and operand width (≥8)
- ADDR_W, 6, byte-address width; low 2 bits ignored, word index = addr[ADDR_W-1:2]
- NUM_SCRATCH, 4, number of R/W scratch registers (7+NUM_SCRATCH ≤ 2^(ADDR_W-2))
- HAL_ID, 32'h055A_0002, constant returned by the ID register (truncated/zero-extended to DATA_W)

- hal_clk  in  1  sole clock, rising edge
- hal_reset  in  1  asynchronous, active-high reset
- reg_itf_write_in  in  1  write strobe, one transfer per high cycle
- reg_itf_read_in  in  1  read strobe, one transfer per high cycle
- reg_itf_addr_in  in  ADDR_W  byte address
- reg_itf_writedata_in  in  DATA_W  write data
- reg_itf_readdata_out  out  DATA_W  registered read data
- reg_itf_readdatavalid_out  out  1  one-cycle pulse qualifying readdata
- irq_out  out  1  level interrupt = STATUS.done & CTRL.irq_en

## Operation
- Word map: 0 ID (RO); 1 CTRL; 2 STATUS; 3 OP_A; 4 OP_B; 5 RES_LO (RO); 6 RES_HI (RO); 7..6+NUM_SCRATCH SCRATCH[i] (R/W).
- CTRL: bit0 start (write-1 pulse, reads 0); bits[2:1] op (00 add, 01 sub, 10 mul, 11 reserved); bit3 irq_en. Other bits read 0.
- STATUS: bit0 busy (RO); bit1 done (sticky, W1C); bit2 err (sticky, W1C). Other bits read 0.
- Writes to RO or unmapped words are ignored; reads of unmapped words return 0.
- Operands are latched into the engine on start; OP_A/OP_B may be rewritten while busy without affecting the running op.
- FSM: IDLE -> RUN on accepted start with op ≠ 11; RUN -> IDLE when the op completes (add/sub after 1 cycle, mul after DATA_W cycles).
- add: RES_LO = (A+B) mod 2^DATA_W; RES_HI = carry, zero-extended.
- sub: RES_LO = (A−B) mod 2^DATA_W; RES_HI = borrow (1 iff A<B unsigned), zero-extended.
- mul: unsigned 2·DATA_W-bit product, one shift-add step per cycle; {RES_HI,RES_LO} = A·B.
- Completion: RES_* updated, done←1, busy←0 in the same cycle.
- An accepted start clears done, clears neither err nor RES_* (RES_* hold the old result until completion).
- Start with op=11: not accepted, err←1, FSM stays IDLE.
- Start while busy: ignored, err←1, running op unaffected.
- CTRL write with start=0 updates op/irq_en only. A W1C write to done in the completion cycle: set wins.
- Reset (any time, including mid-RUN): FSM IDLE, all registers 0 (CTRL, STATUS, OP_*, RES_*, SCRATCH); readdata_out=0, readdatavalid_out=0, irq_out=0.

## Timing
- Read: strobe sampled at edge T; readdata_out/readdatavalid_out valid after edge T, for one cycle. Back-to-back reads return one word per cycle. readdata holds its last value when not valid.
- Write: takes effect at the sampling edge and is visible to a read issued the following cycle.
- Simultaneous read and write in one cycle (any addresses): both performed; the read returns the pre-write value.
- Start written at edge T: busy=1 after T. add/sub: done=1, busy=0 after T+1 (2-cycle latency). mul: done=1 after T+DATA_W.
- irq_out is combinational from registered done and irq_en; it has no extra latency.

## Test plan
- Reset, then read ID -> readdata 0x055A_0002 with valid pulse exactly one cycle after strobe; read STATUS -> 0.
- OP_A=0xFFFF_FFFF, OP_B=2, CTRL=0b0001 (add) -> busy for 1 cycle, RES_LO=0x0000_0001, RES_HI=1, done=1; write STATUS=0b010 -> done=0.
- OP_A=3, OP_B=5, sub -> RES_LO=0xFFFF_FFFE, RES_HI=1; mul OP_A=0xFFFF_FFFF, OP_B=0xFFFF_FFFF -> done 32 cycles after start, RES_HI=0xFFFF_FFFE, RES_LO=0x0000_0001.
- irq_en=1 mul 7×6 -> irq_out rises with done, RES_LO=42; restart during busy -> err=1, result still 42; CTRL op=11 start -> err=1, busy stays 0.
- Scratch: write SCRATCH[0..3]=i+0xA0, same-cycle read/write on SCRATCH[1] returns old value; write to RES_LO and unmapped word ignored, unmapped read returns 0.
- Assert hal_reset asynchronously mid-mul -> busy, done, RES_*, irq_out all 0 immediately; subsequent add runs normally.
